// File: rtl/byte_unstriping.sv
// Two-lane to one-stream merger: locks onto the lane phase at the first valid word,
// then reads the lanes alternately, flagging phase violations and counting words.
module byte_unstriping #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk_2f,
   input  logic             reset_L,
   input  logic [WIDTH-1:0] lane_0,
   input  logic             valid_0,
   input  logic [WIDTH-1:0] lane_1,
   input  logic             valid_1,
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic             phase_err,
   output logic [CNT_W-1:0] word_count
);

   typedef enum logic {
      ALIGN = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             sel_q, sel_d;
   logic [1:0]       pv_q;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] lane_w [2];
   logic [1:0]       valid_w;
   logic [1:0]       rise_w;
   logic             pick;
   logic             other;
   logic             check_en;

   assign lane_w[0] = lane_0;
   assign lane_w[1] = lane_1;
   assign valid_w   = {valid_1, valid_0};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign rise_w[gi] = valid_w[gi] & ~pv_q[gi];
      end
   endgenerate

   // pick is the lane consumed on this edge; the other lane must hold its valid steady
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      data_d   = '0;
      valid_d  = 1'b0;
      err_d    = err_q;
      cnt_d    = cnt_q;
      pick     = sel_q;
      check_en = 1'b0;

      case (state_q)
         ALIGN: begin
            if (rise_w[0]) begin
               pick     = 1'b0;
               data_d   = lane_w[0];
               valid_d  = 1'b1;
               sel_d    = 1'b1;
               state_d  = RUN;
               check_en = 1'b1;
            end else if (rise_w[1]) begin
               pick     = 1'b1;
               data_d   = lane_w[1];
               valid_d  = 1'b1;
               sel_d    = 1'b0;
               state_d  = RUN;
               check_en = 1'b1;
            end
         end
         RUN: begin
            pick     = sel_q;
            check_en = 1'b1;
            sel_d    = ~sel_q;
            if (valid_w[pick]) begin
               data_d  = lane_w[pick];
               valid_d = 1'b1;
            end
         end
         default: state_d = ALIGN;
      endcase

      other = ~pick;
      if (check_en && (valid_w[other] != pv_q[other])) begin
         err_d = 1'b1;
      end

      if (valid_d && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_2f or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= ALIGN;
         sel_q   <= 1'b0;
         pv_q    <= 2'b00;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         pv_q    <= valid_w;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign data_out   = data_q;
   assign valid_out  = valid_q;
   assign phase_err  = err_q;
   assign word_count = cnt_q;

endmodule

// File: tb/tb_byte_unstriping.sv
// Bench for byte_unstriping: an upstream striper model writes alternating lanes and
// queues each valid word with the cycle it must appear; a monitor checks order and latency.
module tb_byte_unstriping;

   localparam int WIDTH = 32;
   localparam int CNT_W = 16;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk_2f;
   logic             reset_L;
   logic [WIDTH-1:0] lane_0, lane_1;
   logic             valid_0, valid_1;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             phase_err;
   logic [CNT_W-1:0] word_count;

   byte_unstriping #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk_2f     (clk_2f),
      .reset_L    (reset_L),
      .lane_0     (lane_0),
      .valid_0    (valid_0),
      .lane_1     (lane_1),
      .valid_1    (valid_1),
      .data_out   (data_out),
      .valid_out  (valid_out),
      .phase_err  (phase_err),
      .word_count (word_count)
   );

   typedef struct {
      logic [WIDTH-1:0] d;
      int               t;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   exp_cnt = 0;
   bit   wp = 0;
   bit   inj_next = 0;

   initial clk_2f = 1'b0;
   always #5 clk_2f = ~clk_2f;
   always @(posedge clk_2f) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One upstream slot: the next lane in stripe order gets a word written just after the edge
   task automatic slot(input bit v, input logic [WIDTH-1:0] d);
      @(posedge clk_2f);
      #1;
      if (wp == 1'b0) begin
         lane_0  = d;
         valid_0 = v;
         if (inj_next) valid_1 = ~valid_1;
      end else begin
         lane_1  = d;
         valid_1 = v;
      end
      inj_next = 0;
      if (v) begin
         q.push_back('{d: d, t: cyc + 1});
         if (exp_cnt < CMAX) exp_cnt++;
      end
      wp = ~wp;
   endtask

   task automatic drain();
      slot(1'b0, '0);
      slot(1'b0, '0);
      @(negedge clk_2f);
      chk("queue_empty", 32'(q.size()), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk_2f);
      #1;
      reset_L = 1'b0;
      #1;
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("rst_phase_err", {31'd0, phase_err}, 32'd0);
      chk("rst_word_count", {16'd0, word_count}, 32'd0);
      q.delete();
      lane_0 = '0; lane_1 = '0; valid_0 = 1'b0; valid_1 = 1'b0;
      wp = 0; exp_cnt = 0; inj_next = 0;
      repeat (2) @(posedge clk_2f);
      #2;
      reset_L = 1'b1;
   endtask

   // Monitor: every delivered word must be the oldest outstanding one, on its due cycle
   always @(negedge clk_2f) begin
      if (reset_L) begin
         if (valid_out) begin
            if (q.size() == 0) begin
               chk("unexpected_word", data_out, 32'hDEAD_BEEF ^ data_out ^ 32'h1);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("data_out", data_out, e.d);
               chk("latency", 32'(cyc), 32'(e.t));
               $display("word 0x%08h at cycle %0d count %0d", data_out, cyc, word_count);
            end
         end else begin
            chk("idle_data_zero", data_out, 32'h0);
         end
         if (q.size() > 0 && q[0].t < cyc) begin
            exp_t m;
            m = q.pop_front();
            chk("missing_word", 32'(cyc), 32'(m.t));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_L = 1'b0;
      lane_0 = '0; lane_1 = '0; valid_0 = 1'b0; valid_1 = 1'b0;
      repeat (2) @(posedge clk_2f);
      #2;
      reset_L = 1'b1;
      repeat (3) slot(1'b0, '0);

      // lane 0 first
      slot(1'b1, 32'h1111_1111);
      slot(1'b1, 32'h2222_2222);
      slot(1'b1, 32'h3333_3333);
      slot(1'b1, 32'h4444_4444);
      drain();
      chk("lane0_count", {16'd0, word_count}, 32'(exp_cnt));
      chk("lane0_err", {31'd0, phase_err}, 32'd0);

      // random traffic with idle slots on the established phase
      for (int i = 0; i < 300; i++) begin
         slot(($urandom_range(0, 3) != 0), $urandom);
      end
      drain();
      chk("rand_count", {16'd0, word_count}, 32'(exp_cnt));
      chk("rand_err", {31'd0, phase_err}, 32'd0);

      // mid-stream reset
      slot(1'b1, 32'h5555_0001);
      slot(1'b1, 32'h5555_0002);
      slot(1'b1, 32'h5555_0003);
      do_reset();
      repeat (4) slot(1'b0, '0);
      chk("align_idle_count", {16'd0, word_count}, 32'd0);

      // lane 1 first
      wp = 1;
      slot(1'b1, 32'hAAAA_0001);
      slot(1'b1, 32'hAAAA_0002);
      slot(1'b1, 32'hAAAA_0003);
      drain();
      chk("lane1_count", {16'd0, word_count}, 32'(exp_cnt));
      chk("lane1_err", {31'd0, phase_err}, 32'd0);

      // idle gap
      do_reset();
      slot(1'b1, 32'h1);
      slot(1'b0, 32'h0);
      slot(1'b1, 32'h3);
      drain();
      chk("gap_count", {16'd0, word_count}, 32'd2);

      // phase violation: lane 1 valid toggles while lane 0 is being consumed
      do_reset();
      slot(1'b1, 32'hC0DE_0000);
      slot(1'b1, 32'hC0DE_0001);
      inj_next = 1;
      slot(1'b1, 32'hC0DE_0002);
      @(negedge clk_2f);
      chk("perr_before", {31'd0, phase_err}, 32'd0);
      slot(1'b1, 32'hC0DE_0003);
      @(negedge clk_2f);
      chk("perr_set", {31'd0, phase_err}, 32'd1);
      for (int i = 0; i < 20; i++) slot(1'b1, $urandom);
      drain();
      chk("perr_sticky", {31'd0, phase_err}, 32'd1);
      chk("perr_count", {16'd0, word_count}, 32'(exp_cnt));

      // both lanes rise on the same edge
      do_reset();
      repeat (2) slot(1'b0, '0);
      @(posedge clk_2f);
      #1;
      lane_0 = 32'hB0B0_0000; valid_0 = 1'b1;
      lane_1 = 32'hB1B1_0001; valid_1 = 1'b1;
      q.push_back('{d: 32'hB0B0_0000, t: cyc + 1});
      q.push_back('{d: 32'hB1B1_0001, t: cyc + 2});
      @(posedge clk_2f);
      #1;
      lane_0 = '0; valid_0 = 1'b0;
      @(posedge clk_2f);
      #1;
      lane_1 = '0; valid_1 = 1'b0;
      repeat (3) @(negedge clk_2f);
      chk("dual_queue_empty", 32'(q.size()), 32'd0);
      chk("dual_err", {31'd0, phase_err}, 32'd1);
      chk("dual_count", {16'd0, word_count}, 32'd2);

      // saturation
      do_reset();
      for (int i = 0; i < CMAX - 1; i++) slot(1'b1, $urandom);
      drain();
      chk("sat_fffe", {16'd0, word_count}, 32'h0000_FFFE);
      repeat (3) slot(1'b1, $urandom);
      drain();
      chk("sat_ffff", {16'd0, word_count}, 32'h0000_FFFF);
      repeat (2) slot(1'b1, $urandom);
      drain();
      chk("sat_hold", {16'd0, word_count}, 32'h0000_FFFF);
      chk("sat_err", {31'd0, phase_err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
